// File: rtl/arrowspace_round_ctrl.sv
// Arrowspace game-round sequencer: start/show/play/clear/miss/over/win phases.
// Owns level, lives and the phase timer; drives seq_reset and show/play enables.
module arrowspace_round_ctrl #(
    parameter int TIMER_W     = 28,
    parameter int SHOW_TICKS  = 50000000,
    parameter int ROUND_TICKS = 2**28-1,
    parameter int START_LIVES = 7,
    parameter int WIN_LEVEL   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_event,
    input  logic       key_correct,
    input  logic       seq_done,
    output logic [2:0] state,
    output logic [1:0] level,
    output logic [2:0] total_life,
    output logic       seq_reset,
    output logic       show_en,
    output logic       play_en,
    output logic       timeout,
    output logic       win,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        MISS  = 3'd4,
        OVER  = 3'd5,
        WON   = 3'd6
    } state_e;

    localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] ROUND_LAST = TIMER_W'(ROUND_TICKS - 1);
    localparam logic [2:0]         LIVES0     = 3'(START_LIVES);
    localparam logic [1:0]         WIN_LV     = 2'(WIN_LEVEL);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         level_q, level_d;
    logic [2:0]         life_q, life_d;
    logic               tmo_d, tmo_q;
    logic               seq_reset_q, show_q, play_q, win_q, over_q;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        life_d  = life_q;
        tmo_d   = 1'b0;
        timer_d = '0;
        case (state_q)
            IDLE: if (start) state_d = SHOW;
            SHOW: if (timer_q == SHOW_LAST) state_d = PLAY;
            PLAY: begin
                // A bad key outranks seq_done, which outranks the timeout.
                if (key_event && !key_correct) begin
                    state_d = MISS;
                end else if (seq_done) begin
                    state_d = CLEAR;
                end else if (timer_q == ROUND_LAST) begin
                    state_d = MISS;
                    tmo_d   = 1'b1;
                end
            end
            CLEAR: begin
                level_d = level_q + 2'd1;
                state_d = (level_d == WIN_LV) ? WON : SHOW;
            end
            MISS: begin
                life_d  = (life_q == 3'd0) ? 3'd0 : life_q - 3'd1;
                state_d = (life_q <= 3'd1) ? OVER : SHOW;
            end
            OVER, WON: if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            level_d = '0;
            life_d  = LIVES0;
        end
        if (state_d == state_q && (state_q == SHOW || state_q == PLAY)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            level_q     <= '0;
            life_q      <= LIVES0;
            tmo_q       <= 1'b0;
            seq_reset_q <= 1'b0;
            show_q      <= 1'b0;
            play_q      <= 1'b0;
            win_q       <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            level_q     <= level_d;
            life_q      <= life_d;
            tmo_q       <= tmo_d;
            seq_reset_q <= (state_d == SHOW) && (state_q != SHOW);
            show_q      <= (state_d == SHOW);
            play_q      <= (state_d == PLAY);
            win_q       <= (state_d == WON);
            over_q      <= (state_d == OVER);
        end
    end

    assign state      = state_q;
    assign level      = level_q;
    assign total_life = life_q;
    assign seq_reset  = seq_reset_q;
    assign show_en    = show_q;
    assign play_en    = play_q;
    assign timeout    = tmo_q;
    assign win        = win_q;
    assign game_over  = over_q;

endmodule
